// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory port arbiter.
//   - access size encodings (SIZE_BYTE/HALF/WORD; the fourth code is illegal)
//   - requester port indices
//   - arbiter FSM state type
//   - gen_mask():     byte-lane write mask for a sized access
//   - load_extract(): lane select plus sign/zero extension of load data
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // StLockN means port N owns the memory until the lock is released.
   typedef enum logic [1:0] {
      StFree  = 2'd0,
      StLock0 = 2'd1,
      StLock1 = 2'd2
   } arb_state_e;

   function automatic logic [3:0] gen_mask(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] mask;
      case (size)
         SIZE_BYTE: mask = 4'b0001 << addr_lo;
         SIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: mask = 4'b1111;
         default:   mask = 4'b0000;
      endcase
      return mask;
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  addr_lo,
                                                input logic        is_unsigned);
      logic [31:0] shifted;
      logic [31:0] result;
      // Move the addressed lane down to bit 0; halves are aligned so this also works for them.
      shifted = word >> {addr_lo, 3'b000};
      case (size)
         SIZE_BYTE: result = is_unsigned ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
         SIZE_HALF: result = is_unsigned ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
         SIZE_WORD: result = word;
         default:   result = 32'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: one requester's request/response bundle.
//   valid/ready        request handshake, transfer when both high
//   write              1 = store, 0 = load
//   addr               byte address
//   wdata              right-aligned store data
//   size               0 byte, 1 half, 2 word, 3 illegal
//   is_unsigned        zero-extend loads
//   lock               keep the grant for the next cycle
//   resp_valid         one-cycle response pulse
//   resp_rdata         load result (0 for stores and errors)
//   resp_error         misaligned, out-of-range or illegal size
// master = requester side, slave = arbiter side.
interface dmem_port_arbiter_if;
   logic        valid;
   logic        ready;
   logic        write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  size;
   logic        is_unsigned;
   logic        lock;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output valid, write, addr, wdata, size, is_unsigned, lock,
      input  ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  valid, write, addr, wdata, size, is_unsigned, lock,
      output ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane handling for one memory access.
//   size_i, addr_lo_i   access size and byte offset within the word
//   wdata_i             right-aligned store data
//   rdata_i             raw memory word
//   unsigned_i          zero-extend loads
//   wdata_o             store data replicated across every lane it may land in
//   mask_o              byte-lane write mask
//   load_o              extracted and extended load value
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   input  logic        unsigned_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  mask_o,
   output logic [31:0] load_o
);

   always_comb begin
      wdata_o = wdata_i;
      case (size_i)
         SIZE_BYTE: wdata_o = {4{wdata_i[7:0]}};
         SIZE_HALF: wdata_o = {2{wdata_i[15:0]}};
         default:   wdata_o = wdata_i;
      endcase
   end

   assign mask_o = gen_mask(size_i, addr_lo_i);
   assign load_o = load_extract(rdata_i, size_i, addr_lo_i, unsigned_i);

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares a single-port word memory between two requesters.
//   clk_i, reset_i        clock, synchronous active-high reset
//   r0_if, r1_if          requester ports (0 = load/store unit, 1 = debug/loader)
//   mem_write_enable_o    memory write strobe
//   mem_address_o         word address
//   mem_write_data_o      lane-replicated store data
//   mem_write_mask_o      byte-lane mask
//   mem_read_data_i       combinational read data for mem_address_o
// Round-robin between valid requesters; a requester may hold the memory with
// lock for at most LOCK_MAX consecutive grants. Responses are registered and
// appear exactly one cycle after acceptance on the granted port only.
module dmem_port_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LOCK_MAX   = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   dmem_port_arbiter_if.slave    r0_if,
   dmem_port_arbiter_if.slave    r1_if,
   output logic                  mem_write_enable_o,
   output logic [ADDR_WIDTH-1:0] mem_address_o,
   output logic [31:0]           mem_write_data_o,
   output logic [3:0]            mem_write_mask_o,
   input  logic [31:0]           mem_read_data_i
);

   localparam logic [3:0] LockMax = 4'(LOCK_MAX);

   arb_state_e        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [3:0]        lock_cnt_q, lock_cnt_d;
   logic [3:0]        lock_cnt_inc;

   logic              gnt0, gnt1;
   logic              sel;
   logic              accept;
   logic              sel_write;
   logic [31:0]       sel_addr;
   logic [31:0]       sel_wdata;
   logic [1:0]        sel_size;
   logic              sel_unsigned;
   logic              sel_lock;
   logic              misaligned;
   logic              out_of_range;
   logic              req_error;

   logic [31:0]       align_wdata;
   logic [3:0]        align_mask;
   logic [31:0]       align_load;
   logic [31:0]       resp_data;

   logic [1:0]        resp_valid_q, resp_valid_d;
   logic [1:0][31:0]  resp_rdata_q, resp_rdata_d;
   logic [1:0]        resp_error_q, resp_error_d;

   // Grant: a lock owner keeps the grant even while idle so the idle cycle can release it.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset_i) begin
         unique case (state_q)
            StLock0: gnt0 = 1'b1;
            StLock1: gnt1 = 1'b1;
            default: begin
               if (r0_if.valid && r1_if.valid) begin
                  gnt0 = last_grant_q;
                  gnt1 = !last_grant_q;
               end else begin
                  gnt0 = r0_if.valid;
                  gnt1 = r1_if.valid;
               end
            end
         endcase
      end
   end

   assign sel    = gnt1 ? PORT1 : PORT0;
   assign accept = (gnt0 && r0_if.valid) || (gnt1 && r1_if.valid);

   assign sel_write    = gnt1 ? r1_if.write       : r0_if.write;
   assign sel_addr     = gnt1 ? r1_if.addr        : r0_if.addr;
   assign sel_wdata    = gnt1 ? r1_if.wdata       : r0_if.wdata;
   assign sel_size     = gnt1 ? r1_if.size        : r0_if.size;
   assign sel_unsigned = gnt1 ? r1_if.is_unsigned : r0_if.is_unsigned;
   assign sel_lock     = gnt1 ? r1_if.lock        : r0_if.lock;

   always_comb begin
      misaligned = 1'b0;
      case (sel_size)
         SIZE_BYTE: misaligned = 1'b0;
         SIZE_HALF: misaligned = sel_addr[0];
         SIZE_WORD: misaligned = |sel_addr[1:0];
         default:   misaligned = 1'b1;
      endcase
   end

   assign out_of_range = |sel_addr[31:ADDR_WIDTH+2];
   assign req_error    = misaligned || out_of_range;

   dmem_lane_align u_lane_align (
      .size_i     (sel_size),
      .addr_lo_i  (sel_addr[1:0]),
      .wdata_i    (sel_wdata),
      .rdata_i    (mem_read_data_i),
      .unsigned_i (sel_unsigned),
      .wdata_o    (align_wdata),
      .mask_o     (align_mask),
      .load_o     (align_load)
   );

   assign mem_write_enable_o = accept && sel_write && !req_error;
   assign mem_address_o      = accept ? sel_addr[ADDR_WIDTH+1:2] : '0;
   assign mem_write_data_o   = mem_write_enable_o ? align_wdata : '0;
   assign mem_write_mask_o   = mem_write_enable_o ? align_mask : '0;

   // Arbiter FSM, lock counter and round-robin pointer.
   assign lock_cnt_inc = lock_cnt_q + 4'd1;

   always_comb begin
      state_d      = state_q;
      lock_cnt_d   = lock_cnt_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         last_grant_d = sel;
         // Reaching LockMax on this grant releases immediately.
         if (sel_lock && (lock_cnt_inc < LockMax)) begin
            state_d    = gnt1 ? StLock1 : StLock0;
            lock_cnt_d = lock_cnt_inc;
         end else begin
            state_d    = StFree;
            lock_cnt_d = 4'd0;
         end
      end else if (state_q != StFree) begin
         // Owner dropped valid while holding the lock.
         state_d    = StFree;
         lock_cnt_d = 4'd0;
      end
   end

   assign resp_data = (sel_write || req_error) ? 32'b0 : align_load;

   always_comb begin
      resp_valid_d = '0;
      resp_rdata_d = '0;
      resp_error_d = '0;
      if (accept) begin
         resp_valid_d[sel] = 1'b1;
         resp_rdata_d[sel] = resp_data;
         resp_error_d[sel] = req_error;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StFree;
         lock_cnt_q   <= 4'd0;
         last_grant_q <= PORT1;
         resp_valid_q <= '0;
         resp_rdata_q <= '0;
         resp_error_q <= '0;
      end else begin
         state_q      <= state_d;
         lock_cnt_q   <= lock_cnt_d;
         last_grant_q <= last_grant_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
      end
   end

   assign r0_if.ready      = gnt0;
   assign r1_if.ready      = gnt1;
   assign r0_if.resp_valid = resp_valid_q[0];
   assign r1_if.resp_valid = resp_valid_q[1];
   assign r0_if.resp_rdata = resp_rdata_q[0];
   assign r1_if.resp_rdata = resp_rdata_q[1];
   assign r0_if.resp_error = resp_error_q[0];
   assign r1_if.resp_error = resp_error_q[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed self-checking bench for dmem_port_arbiter
// with a behavioural 1024-word memory attached to the memory port.
module tb_dmem_port_arbiter;
   import dmem_pkg::*;

   logic        clk;
   logic        reset;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_mask;
   logic [31:0] mem_rdata;
   logic [31:0] mem [0:1023];

   int vectors     = 0;
   int miscompares = 0;

   dmem_port_arbiter_if r0_if ();
   dmem_port_arbiter_if r1_if ();

   dmem_port_arbiter #(
      .ADDR_WIDTH (10),
      .LOCK_MAX   (4)
   ) dut (
      .clk_i              (clk),
      .reset_i            (reset),
      .r0_if              (r0_if),
      .r1_if              (r1_if),
      .mem_write_enable_o (mem_we),
      .mem_address_o      (mem_addr),
      .mem_write_data_o   (mem_wdata),
      .mem_write_mask_o   (mem_mask),
      .mem_read_data_i    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end
   assign mem_rdata = mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int p, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic un, input logic lk);
      if (p == 0) begin
         r0_if.valid = 1'b1; r0_if.write = wr; r0_if.addr = a; r0_if.wdata = wd;
         r0_if.size = sz; r0_if.is_unsigned = un; r0_if.lock = lk;
      end else begin
         r1_if.valid = 1'b1; r1_if.write = wr; r1_if.addr = a; r1_if.wdata = wd;
         r1_if.size = sz; r1_if.is_unsigned = un; r1_if.lock = lk;
      end
   endtask

   task automatic drop(input int p);
      if (p == 0) begin r0_if.valid = 1'b0; r0_if.lock = 1'b0; end
      else begin r1_if.valid = 1'b0; r1_if.lock = 1'b0; end
   endtask

   // Port 0 store: check write strobe, then the response one cycle later.
   task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz);
      req(0, 1'b1, a, wd, sz, 1'b0, 1'b0);
      #1;
      chk({tag, "_we"}, 32'(mem_we), 32'd1);
      tick();
      chk({tag, "_rv"}, 32'(r0_if.resp_valid), 32'd1);
      chk({tag, "_rdata"}, r0_if.resp_rdata, 32'd0);
   endtask

   task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                          input logic un, input logic [31:0] exp);
      req(0, 1'b0, a, 32'd0, sz, un, 1'b0);
      tick();
      chk({tag, "_rv"}, 32'(r0_if.resp_valid), 32'd1);
      chk({tag, "_rdata"}, r0_if.resp_rdata, exp);
      chk({tag, "_err"}, 32'(r0_if.resp_error), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      r0_if.valid = 1'b0; r0_if.write = 1'b0; r0_if.addr = '0; r0_if.wdata = '0;
      r0_if.size = '0; r0_if.is_unsigned = 1'b0; r0_if.lock = 1'b0;
      r1_if.valid = 1'b0; r1_if.write = 1'b0; r1_if.addr = '0; r1_if.wdata = '0;
      r1_if.size = '0; r1_if.is_unsigned = 1'b0; r1_if.lock = 1'b0;

      // Reset: ready low even with a valid request, responses cleared.
      req(0, 1'b0, 32'h10, 32'd0, SIZE_WORD, 1'b0, 1'b0);
      #2;
      chk("rst_ready0", 32'(r0_if.ready), 32'd0);
      chk("rst_ready1", 32'(r1_if.ready), 32'd0);
      tick();
      tick();
      chk("rst_rv0", 32'(r0_if.resp_valid), 32'd0);
      chk("rst_rv1", 32'(r1_if.resp_valid), 32'd0);
      chk("rst_rdata0", r0_if.resp_rdata, 32'd0);
      chk("rst_err0", 32'(r0_if.resp_error), 32'd0);
      reset = 1'b0;
      drop(0);
      #1;
      chk("idle_we", 32'(mem_we), 32'd0);
      chk("idle_addr", 32'(mem_addr), 32'd0);
      chk("idle_mask", 32'(mem_mask), 32'd0);

      // Word store then load back-to-back.
      req(0, 1'b1, 32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b0, 1'b0);
      #1;
      chk("st_ready", 32'(r0_if.ready), 32'd1);
      chk("st_we", 32'(mem_we), 32'd1);
      chk("st_addr", 32'(mem_addr), 32'd4);
      chk("st_mask", 32'(mem_mask), 32'hF);
      chk("st_wdata", mem_wdata, 32'hDEADBEEF);
      tick();
      chk("st_rv", 32'(r0_if.resp_valid), 32'd1);
      chk("st_rdata", r0_if.resp_rdata, 32'd0);
      chk("st_rv_other", 32'(r1_if.resp_valid), 32'd0);
      do_load("ld_word", 32'h10, SIZE_WORD, 1'b0, 32'hDEADBEEF);

      // Sign handling on 0x80FF7F01.
      do_store("st_80ff", 32'h20, 32'h80FF7F01, SIZE_WORD);
      do_load("lb_23", 32'h23, SIZE_BYTE, 1'b0, 32'hFFFFFF80);
      do_load("lbu_23", 32'h23, SIZE_BYTE, 1'b1, 32'h00000080);
      do_load("lh_20", 32'h20, SIZE_HALF, 1'b0, 32'h00007F01);
      do_load("lh_22", 32'h22, SIZE_HALF, 1'b0, 32'hFFFF80FF);

      // Byte store into lane 1.
      do_store("st_1122", 32'h20, 32'h11223344, SIZE_WORD);
      req(0, 1'b1, 32'h21, 32'h000000AB, SIZE_BYTE, 1'b0, 1'b0);
      #1;
      chk("sb_mask", 32'(mem_mask), 32'h2);
      chk("sb_wdata", mem_wdata, 32'hABABABAB);
      tick();
      chk("sb_rv", 32'(r0_if.resp_valid), 32'd1);
      do_load("ld_merged", 32'h20, SIZE_WORD, 1'b0, 32'h1122AB44);
      drop(0);
      tick();

      // Contention: r0 was served last, so r1 goes first, then alternate.
      req(0, 1'b0, 32'h10, 32'd0, SIZE_WORD, 1'b0, 1'b0);
      req(1, 1'b0, 32'h20, 32'd0, SIZE_WORD, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_ready1", 32'(r1_if.ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_ready0", 32'(r0_if.ready), (i % 2 == 0) ? 32'd0 : 32'd1);
         tick();
         chk("rr_rv1", 32'(r1_if.resp_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_rv0", 32'(r0_if.resp_valid), (i % 2 == 0) ? 32'd0 : 32'd1);
         if (i % 2 == 0) chk("rr_rdata1", r1_if.resp_rdata, 32'h1122AB44);
         else chk("rr_rdata0", r0_if.resp_rdata, 32'hDEADBEEF);
      end

      // Lock bound: r1 holds four grants, then r0 gets through.
      req(1, 1'b0, 32'h10, 32'd0, SIZE_WORD, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("lk_ready1", 32'(r1_if.ready), 32'd1);
         chk("lk_ready0", 32'(r0_if.ready), 32'd0);
         tick();
      end
      #1;
      chk("lk_rel_ready0", 32'(r0_if.ready), 32'd1);
      chk("lk_rel_ready1", 32'(r1_if.ready), 32'd0);
      tick();
      #1;
      chk("lk_again_ready1", 32'(r1_if.ready), 32'd1);
      tick();

      // Reset while r1 holds a lock with its response showing.
      chk("lk_pend_rv1", 32'(r1_if.resp_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("rstlk_ready0", 32'(r0_if.ready), 32'd0);
      chk("rstlk_ready1", 32'(r1_if.ready), 32'd0);
      tick();
      chk("rstlk_rv1", 32'(r1_if.resp_valid), 32'd0);
      chk("rstlk_rv0", 32'(r0_if.resp_valid), 32'd0);
      reset = 1'b0;
      #1;
      chk("rstlk_first0", 32'(r0_if.ready), 32'd1);
      chk("rstlk_first1", 32'(r1_if.ready), 32'd0);
      drop(0);
      drop(1);
      tick();

      // Errors: misaligned word load, out-of-range store, misaligned half, size 3.
      req(0, 1'b0, 32'h2, 32'd0, SIZE_WORD, 1'b0, 1'b0);
      #1;
      chk("e_mis_we", 32'(mem_we), 32'd0);
      tick();
      chk("e_mis_rv", 32'(r0_if.resp_valid), 32'd1);
      chk("e_mis_err", 32'(r0_if.resp_error), 32'd1);
      chk("e_mis_rdata", r0_if.resp_rdata, 32'd0);
      req(0, 1'b1, 32'h1000, 32'h12345678, SIZE_WORD, 1'b0, 1'b0);
      #1;
      chk("e_oor_we", 32'(mem_we), 32'd0);
      chk("e_oor_mask", 32'(mem_mask), 32'd0);
      tick();
      chk("e_oor_err", 32'(r0_if.resp_error), 32'd1);
      chk("e_oor_rdata", r0_if.resp_rdata, 32'd0);
      req(0, 1'b1, 32'h21, 32'h5555, SIZE_HALF, 1'b0, 1'b0);
      #1;
      chk("e_half_we", 32'(mem_we), 32'd0);
      tick();
      chk("e_half_err", 32'(r0_if.resp_error), 32'd1);
      req(0, 1'b0, 32'h20, 32'd0, 2'd3, 1'b0, 1'b0);
      tick();
      chk("e_sz3_err", 32'(r0_if.resp_error), 32'd1);
      chk("e_sz3_rdata", r0_if.resp_rdata, 32'd0);
      drop(0);
      tick();
      chk("end_rv0", 32'(r0_if.resp_valid), 32'd0);
      chk("end_err0", 32'(r0_if.resp_error), 32'd0);

      // Erroring requests must not have disturbed memory.
      do_load("ld_after_err", 32'h20, SIZE_WORD, 1'b0, 32'h1122AB44);
      drop(0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port 1024-word data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/loader).
- Converts byte-addressed, sized requests into word address, lane-shifted write data and 4-bit write mask.
- Returns registered, sign/zero-extended load data.
- Round-robin arbitration with bounded lock, so a requester can run back-to-back accesses such as read-modify-write.

Parameters:
- ADDR_WIDTH, 10, word-address width of the memory (capacity 4*2^ADDR_WIDTH bytes).
- LOCK_MAX, 4, maximum consecutive locked grants before forced release (1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rN_valid  in  1  request valid, N = 0, 1 (each port below is duplicated as r0_ and r1_).
- rN_ready  out  1  grant; a transfer occurs when valid && ready.
- rN_write  in  1  1 = store, 0 = load.
- rN_addr  in  32  byte address.
- rN_wdata  in  32  store data, right-aligned.
- rN_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- rN_unsigned  in  1  load zero-extend (LBU/LHU).
- rN_lock  in  1  keep grant for the next cycle.
- rN_resp_valid  out  1  one-cycle pulse.
- rN_resp_rdata  out  32  load result; 0 for stores and errors.
- rN_resp_error  out  1  misaligned access, out-of-range address or size 3.
- mem_write_enable  out  1  to memory write enable.
- mem_address  out  ADDR_WIDTH  word address.
- mem_write_data  out  32  lane-replicated store data.
- mem_write_mask  out  4  byte-lane mask.
- mem_read_data  in  32  combinational read data from memory.

Behaviour:
- Reset outputs/state:
  - resp_valid, resp_rdata and resp_error = 0 on both ports.
  - last_grant = 1, so port 0 wins first.
  - lock_owner cleared; lock_cnt = 0.
  - ready is combinational and is 0 during reset.
- Grant is combinational from valid, last_grant and lock state:
  - An active lock grants its owner only, even if the owner's valid is low.
  - Otherwise a single valid requester is granted.
  - If both are valid, the grant goes to !last_grant.
  - At most one ready is high per cycle.
- On an accepted transfer: last_grant <= the granted port.
- Lock:
  - If the accepted request has lock = 1, set lock_owner and increment lock_cnt.
  - The lock releases when the owner issues an unlocked transfer, when the owner's valid drops, or when lock_cnt reaches LOCK_MAX; lock_cnt then clears.
  - The other port waits during a lock and may starve for at most LOCK_MAX cycles.
- Memory drive, same cycle as acceptance:
  - mem_address = addr[ADDR_WIDTH+1:2].
  - Byte store: mask = 1 << addr[1:0]; write_data = wdata[7:0] replicated across all 4 lanes.
  - Half store: mask = 0011 or 1100 selected by addr[1]; wdata[15:0] replicated across both halves.
  - Word store: mask = 1111.
  - mem_write_enable = accepted && write && !error. With no grant: mem_write_enable = 0, mask = 0, address = 0.
- Error conditions:
  - Half with addr[0] = 1; word with addr[1:0] != 0; size 3.
  - addr[31:ADDR_WIDTH+2] != 0.
  - On error there is no memory write, resp_error = 1 and rdata = 0.
- Response:
  - Registered, latency exactly 1 cycle after acceptance, pulsed only on the requester that was granted.
  - A load selects the lane from mem_read_data sampled in the acceptance cycle, then sign- or zero-extends per size/unsigned.
  - Stores respond with rdata = 0.
- Throughput: one transfer per cycle. A load immediately after a store to the same word returns the new data.
- Reset mid-lock or with a response pending: the lock is dropped and the pending response is discarded (resp_valid = 0 in the cycle after reset).

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - port index constants;
  - a function for mask generation and a function for load extraction/extension.
- One natural sub-module, dmem_lane_align: combinational store lane replication/mask plus load extract/extend, instantiated once.
- The arbiter FSM and lock counter stay in the top module.

Test Plan:
- Word store then load:
  - r0 store addr 0x10, wdata 0xDEADBEEF, size 2 → mem_address 4, mask 1111.
  - Next-cycle r0 load 0x10 → resp_rdata 0xDEADBEEF one cycle later.
- Byte/half sign handling (memory word at 0x20 = 0x80FF7F01):
  - Load byte 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080.
  - Load half 0x20 → 0x00007F01; half 0x22 → 0xFFFF80FF.
- Byte store lane:
  - Store byte 0xAB at 0x21 over 0x11223344 → mask 0010, word becomes 0x1122AB44.
- Contention round-robin:
  - r0 and r1 valid every cycle → grants alternate 0,1,0,1; each resp_valid appears only on its own port.
- Lock bound (LOCK_MAX = 4):
  - r1 holds lock with r0 valid → r1 granted 4 consecutive cycles, then r0 is granted.
- Errors:
  - Word load at 0x2 and store at 0x1000 → resp_error = 1, rdata 0, mem_write_enable never asserted.
  - Reset asserted during a lock → grant returns to r0 first.
